registers: RTL and testbench

REGISTERS -- requirements
Module: registers

---
 rtl/riscv_pkg.sv | 12 +
 rtl/registers.sv | 89 ++++++++
 tb/tb_registers.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: datapath width,
// register-file geometry and the matching typedefs.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NREGS      = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xlen_t;

endpackage

// File: rtl/registers.sv
// Integer register file: x0 hard-wired to zero,
// two combinational read ports, one write port.
//
// Ports:
//   clk, rst          rising-edge clock, sync active-high reset
//   read_reg1/2       read port addresses
//   read_data1/2      read port data (same-cycle)
//   write_reg         write port address
//   write_data        write port data
//   reg_write_enable  write strobe
module registers
  import riscv_pkg::*;
#(
  parameter int XLEN  = riscv_pkg::XLEN,
  parameter int NREGS = riscv_pkg::NREGS
) (
  input  logic      clk,
  input  logic      rst,
  input  reg_addr_t read_reg1,
  input  reg_addr_t read_reg2,
  input  reg_addr_t write_reg,
  input  xlen_t     write_data,
  input  logic      reg_write_enable,
  output xlen_t     read_data1,
  output xlen_t     read_data2
);

  // No storage for x0; index 0 does not exist.
  logic [XLEN-1:0] regs_q [1:NREGS-1];
  logic [XLEN-1:0] regs_d [1:NREGS-1];

  logic wr_ok;

  assign wr_ok = reg_write_enable
               & (write_reg != '0);

  always_comb begin
    for (int i = 1; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_ok && write_reg == reg_addr_t'(i)) begin
        regs_d[i] = write_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  reg_addr_t rd_addr [2];

  assign rd_addr[0] = read_reg1;
  assign rd_addr[1] = read_reg2;

  // Both read ports are the same mux + bypass.
  // The bypass lets a consumer see a value in the
  // cycle it is written; it is off during reset
  // because the write will be dropped.
  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic            bypass;
    logic [XLEN-1:0] data;

    always_comb begin
      bypass = ~rst & wr_ok
             & (rd_addr[p] == write_reg);
      data = '0;
      for (int i = 1; i < NREGS; i++) begin
        if (rd_addr[p] == reg_addr_t'(i)) begin
          data = regs_q[i];
        end
      end
      if (bypass) begin
        data = write_data;
      end
    end
  end

  assign read_data1 = g_rd[0].data;
  assign read_data2 = g_rd[1].data;

endmodule

// File: tb/tb_registers.sv
// Self-checking bench for the register file:
// directed scenarios plus random traffic vs a model.
module tb_registers;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rr1, rr2, wr;
  logic [31:0] wd;
  logic        we;
  logic [31:0] rd1, rd2;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mem [0:31];

  registers dut (
    .clk              (clk),
    .rst              (rst),
    .read_reg1        (rr1),
    .read_reg2        (rr2),
    .write_reg        (wr),
    .write_data       (wd),
    .reg_write_enable (we),
    .read_data1       (rd1),
    .read_data2       (rd2)
  );

  always #5 clk = ~clk;

  // Architectural view of a read with current inputs.
  function automatic logic [31:0] exp_rd(
    input logic [4:0] a
  );
    if (!rst && we && wr != 0 && a == wr) return wd;
    if (a == 0) return 32'h0;
    return mem[a];
  endfunction

  // One clock edge; model commits what the DUT sees.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    end else if (we && wr != 0) begin
      mem[wr] = wd;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; we = 1'b1; wr = 5'd1;
    wd = $urandom; rr1 = 5'd1; rr2 = 5'd2;
    tick();
    #1;
    n_cmp++;
    if (rd1 !== 32'h0) begin
      n_bad++;
      $display("FAIL rst_no_bypass got %h want %h",
               rd1, 32'h0);
    end
    tick();
    rst = 1'b0; we = 1'b0;
    #1;
    n_cmp++;
    if (rd1 !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_rd1 got %h want %h",
               rd1, 32'h0);
    end
    n_cmp++;
    if (rd2 !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_rd2 got %h want %h",
               rd2, 32'h0);
    end
  endtask

  task automatic test_write_disabled();
    we = 1'b0; wr = 5'd3; wd = 32'h1; rr1 = 5'd3;
    for (int i = 0; i < 10; i++) tick();
    n_cmp++;
    if (rd1 !== 32'h0) begin
      n_bad++;
      $display("FAIL we0_no_write got %h want %h",
               rd1, 32'h0);
    end
  endtask

  task automatic test_write_hold();
    we = 1'b1; wr = 5'd3; wd = 32'h1; rr1 = 5'd3;
    tick();
    we = 1'b0; wd = 32'h2;
    #1;
    n_cmp++;
    if (rd1 !== 32'h1) begin
      n_bad++;
      $display("FAIL write_hold got %h want %h",
               rd1, 32'h1);
    end
    tick();
    n_cmp++;
    if (rd1 !== 32'h1) begin
      n_bad++;
      $display("FAIL write_hold2 got %h want %h",
               rd1, 32'h1);
    end
  endtask

  task automatic test_x0();
    we = 1'b1; wr = 5'd0; wd = 32'hDEADBEEF;
    rr1 = 5'd0;
    #1;
    n_cmp++;
    if (rd1 !== 32'h0) begin
      n_bad++;
      $display("FAIL x0_pre got %h want %h",
               rd1, 32'h0);
    end
    tick();
    n_cmp++;
    if (rd1 !== 32'h0) begin
      n_bad++;
      $display("FAIL x0_post got %h want %h",
               rd1, 32'h0);
    end
    we = 1'b0;
  endtask

  task automatic test_back_to_back();
    we = 1'b1; wr = 5'd5; wd = 32'hA5A5A5A5;
    rr1 = 5'd5; rr2 = 5'd5;
    #1;
    n_cmp++;
    if (rd1 !== 32'hA5A5A5A5) begin
      n_bad++;
      $display("FAIL bypass_rd1 got %h want %h",
               rd1, 32'hA5A5A5A5);
    end
    n_cmp++;
    if (rd2 !== 32'hA5A5A5A5) begin
      n_bad++;
      $display("FAIL bypass_rd2 got %h want %h",
               rd2, 32'hA5A5A5A5);
    end
    tick();
    we = 1'b0; wd = 32'h0;
    #1;
    n_cmp++;
    if (rd1 !== 32'hA5A5A5A5) begin
      n_bad++;
      $display("FAIL stored_rd1 got %h want %h",
               rd1, 32'hA5A5A5A5);
    end
    n_cmp++;
    if (rd2 !== 32'hA5A5A5A5) begin
      n_bad++;
      $display("FAIL stored_rd2 got %h want %h",
               rd2, 32'hA5A5A5A5);
    end
  endtask

  task automatic test_reset_priority();
    we = 1'b1; wr = 5'd7; wd = 32'h1234;
    rr1 = 5'd7;
    tick();
    rst = 1'b1; wd = 32'hFFFF;
    #1;
    n_cmp++;
    if (rd1 !== 32'h1234) begin
      n_bad++;
      $display("FAIL rst_bypass_off got %h want %h",
               rd1, 32'h1234);
    end
    tick();
    rst = 1'b0; we = 1'b0;
    #1;
    n_cmp++;
    if (rd1 !== 32'h0) begin
      n_bad++;
      $display("FAIL rst_prio got %h want %h",
               rd1, 32'h0);
    end
  endtask

  task automatic test_random();
    logic [31:0] e1, e2;
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 49) == 0);
      we  = $urandom_range(0, 2) != 0;
      wr  = 5'($urandom);
      wd  = $urandom;
      rr1 = ($urandom_range(0, 3) == 0)
          ? wr : 5'($urandom);
      rr2 = ($urandom_range(0, 3) == 0)
          ? wr : 5'($urandom);
      #1;
      e1 = exp_rd(rr1);
      e2 = exp_rd(rr2);
      n_cmp++;
      if (rd1 !== e1) begin
        n_bad++;
        $display("FAIL rand_rd1 n=%0d a=%0d got %h want %h",
                 n, rr1, rd1, e1);
      end
      n_cmp++;
      if (rd2 !== e2) begin
        n_bad++;
        $display("FAIL rand_rd2 n=%0d a=%0d got %h want %h",
                 n, rr2, rd2, e2);
      end
      tick();
    end
    rst = 1'b0; we = 1'b0;
    for (int a = 0; a < 32; a++) begin
      rr1 = 5'(a); rr2 = 5'(31 - a);
      #1;
      e1 = exp_rd(rr1);
      e2 = exp_rd(rr2);
      n_cmp++;
      if (rd1 !== e1 || rd2 !== e2) begin
        n_bad++;
        $display("FAIL sweep a=%0d got %h/%h want %h/%h",
                 a, rd1, rd2, e1, e2);
      end
    end
  endtask

  initial begin
    rst = 1'b0; we = 1'b0; wr = '0; wd = '0;
    rr1 = '0; rr2 = '0;
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    #2;
    test_reset();
    test_write_disabled();
    test_write_hold();
    test_x0();
    test_back_to_back();
    test_reset_priority();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
